// File: rtl/hand_score_tracker.sv
// Running blackjack hand totals for player 1, player 2 and dealer, packed for the LCD
// numbers bus, with bust/blackjack flags and dealer hole-card masking.
module hand_score_tracker #(
    parameter int unsigned SAT_LIMIT = 31,
    parameter int unsigned MAX_CARDS = 7
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        card_valid,
    output logic        card_ready,
    input  logic [3:0]  card_rank,
    input  logic [1:0]  card_dest,
    input  logic        clear_hands,
    input  logic        hide_hole,
    output logic [29:0] numbers,
    output logic [2:0]  bust,
    output logic [2:0]  blackjack,
    output logic        card_error
);

    localparam int unsigned SW    = 5;
    localparam int unsigned CW    = 3;
    localparam int unsigned HANDS = 3;

    typedef enum logic [1:0] {IDLE, ADD, CLR} state_t;

    state_t                    state_q, state_d;
    logic [3:0]                rank_q, rank_d;
    logic [1:0]                dest_q, dest_d;
    logic                      err_q, err_d;
    logic [HANDS-1:0][SW-1:0]  sum_q, sum_d;
    logic [HANDS-1:0]          ace_q, ace_d;
    logic [HANDS-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]             up_q, up_d;
    logic                      upace_q, upace_d;
    logic [29:0]               numbers_d;
    logic [2:0]                bust_d, blackjack_d;

    logic                      hs;
    logic                      full_in;
    logic                      discard_in;
    logic [3:0]                val;
    logic [SW:0]               ext;

    function automatic logic [SW-1:0] hand_max(input logic [SW-1:0] s, input logic a);
        return (a && s <= 5'd11) ? s + 5'd10 : s;
    endfunction

    assign card_ready = (state_q == IDLE) && !clear_hands && !reset;
    assign hs         = card_valid && card_ready;
    assign val        = (rank_q == 4'd1) ? 4'd1 : ((rank_q > 4'd10) ? 4'd10 : rank_q);

    // A full target hand is only meaningful for the three legal destinations
    always_comb begin
        full_in = 1'b0;
        for (int i = 0; i < HANDS; i++) begin
            if (card_dest == 2'(i) && cnt_q[i] == CW'(MAX_CARDS)) full_in = 1'b1;
        end
    end

    assign discard_in = (card_rank == 4'd0) || (card_rank > 4'd13) ||
                        (card_dest == 2'd3) || full_in;

    // Next-state and hand bookkeeping
    always_comb begin
        state_d = state_q;
        rank_d  = rank_q;
        dest_d  = dest_q;
        err_d   = 1'b0;
        sum_d   = sum_q;
        ace_d   = ace_q;
        cnt_d   = cnt_q;
        up_d    = up_q;
        upace_d = upace_q;
        ext     = '0;
        unique case (state_q)
            IDLE: begin
                if (clear_hands) begin
                    state_d = CLR;
                end else if (hs) begin
                    rank_d  = card_rank;
                    dest_d  = card_dest;
                    err_d   = discard_in;
                    state_d = ADD;
                end
            end
            ADD: begin
                state_d = IDLE;
                for (int i = 0; i < HANDS; i++) begin
                    if (!err_q && dest_q == 2'(i)) begin
                        ext      = {1'b0, sum_q[i]} + (SW+1)'(val);
                        sum_d[i] = (ext > (SW+1)'(SAT_LIMIT)) ? SW'(SAT_LIMIT) : ext[SW-1:0];
                        cnt_d[i] = cnt_q[i] + CW'(1);
                        if (rank_q == 4'd1) ace_d[i] = 1'b1;
                        if (i == 2 && cnt_q[i] == '0) begin
                            up_d    = SW'(val);
                            upace_d = (rank_q == 4'd1);
                        end
                    end
                end
            end
            CLR: begin
                state_d = IDLE;
                sum_d   = '0;
                ace_d   = '0;
                cnt_d   = '0;
                up_d    = '0;
                upace_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Display fields follow the next-state totals so they appear right after ADD
    always_comb begin
        numbers_d   = '0;
        bust_d      = '0;
        blackjack_d = '0;
        for (int i = 0; i < HANDS; i++) begin
            if (i == 2 && hide_hole) begin
                numbers_d[i*10 +: 5]     = hand_max(up_d, upace_d);
                numbers_d[i*10 + 5 +: 5] = up_d;
            end else begin
                numbers_d[i*10 +: 5]     = hand_max(sum_d[i], ace_d[i]);
                numbers_d[i*10 + 5 +: 5] = sum_d[i];
            end
            bust_d[i]      = sum_d[i] > 5'd21;
            blackjack_d[i] = (cnt_d[i] == CW'(2)) && (hand_max(sum_d[i], ace_d[i]) == 5'd21);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rank_q     <= '0;
            dest_q     <= '0;
            err_q      <= 1'b0;
            sum_q      <= '0;
            ace_q      <= '0;
            cnt_q      <= '0;
            up_q       <= '0;
            upace_q    <= 1'b0;
            numbers    <= '0;
            bust       <= '0;
            blackjack  <= '0;
        end else begin
            state_q    <= state_d;
            rank_q     <= rank_d;
            dest_q     <= dest_d;
            err_q      <= err_d;
            sum_q      <= sum_d;
            ace_q      <= ace_d;
            cnt_q      <= cnt_d;
            up_q       <= up_d;
            upace_q    <= upace_d;
            numbers    <= numbers_d;
            bust       <= bust_d;
            blackjack  <= blackjack_d;
        end
    end

    assign card_error = err_q;

endmodule

// File: doc/hand_score_tracker.md
Name: hand_score_tracker

Overview:
- Upstream feeder of the LCD display top: receives dealt cards one at a time for player 1, player 2 and the dealer.
- Keeps a running hand total for each hand. Computes a "min" total (aces = 1) and a "max" total (one ace = 11 when it does not bust).
- Drives the packed 30-bit numbers bus the display consumes, plus bust/blackjack flags for the game FSM.
- Supports dealer hole-card masking, so the display shows only the upcard until reveal.

Parameters:
- SAT_LIMIT, 31, saturation value for all 5-bit totals.
- MAX_CARDS, 7, maximum cards accepted per hand; further cards are rejected.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- card_valid  in  1  card presented this cycle.
- card_ready  out  1  block can accept a card; a transfer occurs when card_valid && card_ready.
- card_rank  in  4  1=A, 2..10 pips, 11..13 = J/Q/K.
- card_dest  in  2  0=player1, 1=player2, 2=dealer, 3=illegal.
- clear_hands  in  1  single-cycle request to zero all hands (new round).
- hide_hole  in  1  1 = dealer totals show upcard only.
- numbers  out  30  [4:0] p1max, [9:5] p1min, [14:10] p2max, [19:15] p2min, [24:20] dmax, [29:25] dmin.
- bust  out  3  per-hand min total > 21; bit0 = p1, bit1 = p2, bit2 = dealer.
- blackjack  out  3  per-hand: exactly 2 cards and max total == 21.
- card_error  out  1  one-cycle pulse when an accepted card was discarded.

Behaviour:
- Reset (async, active-high): state = IDLE; all sums, ace flags, card counts and the dealer upcard register = 0. numbers = 0, bust = 0, blackjack = 0, card_error = 0. card_ready = 0 while reset is asserted and 1 from the first cycle after release.
- FSM states: IDLE, ADD, CLR.
- card_ready = (state==IDLE) && !clear_hands.
- IDLE transitions:
  - clear_hands=1 -> CLR. Clear has priority; a simultaneous card is not accepted because ready=0.
  - Handshake -> latch rank/dest into registers, go to ADD.
- ADD (1 cycle, ready=0):
  - Value map: rank 1 -> 1 and set that hand's ace flag; 2..10 -> rank; 11..13 -> 10.
  - Target hand sum <= min(sum+value, SAT_LIMIT); card count +1. Return to IDLE.
- Discard conditions: rank 0/14/15, dest 3, or target hand count == MAX_CARDS. The card is still consumed but no state changes, and card_error pulses high during the ADD cycle.
- CLR (1 cycle, ready=0): zero all sums, ace flags, counts and the upcard register -> IDLE.
- Throughput: one card every 2 cycles. Totals and flags are visible on the cycle after ADD, i.e. 2 cycles after the handshake.
- Dealer upcard: the first accepted dealer card's value (ace = 1, ace-flag copy kept) is stored in a separate register.
- Per-hand derivation, registered, from sum S and ace flag A:
  - min = S.
  - max = S+10 if A && S+10 <= 21, else S.
  - All results are 5 bits and saturate at 31; no wrap.
- Dealer fields when hide_hole=1: computed from the upcard register alone. Ace upcard -> dmin=1, dmax=11. Empty hand -> 0/0.
- hide_hole is sampled every cycle; the displayed dealer fields change on the next cycle.
- bust and blackjack always use true dealer totals, regardless of hide_hole.
- bust[i] = min_i > 21.
- blackjack[i] = count_i==2 && max_i==21.
- reset asserted mid-ADD or mid-CLR: immediate return to reset values; the in-flight card is lost.

Test Plan:
- Reset, then p1 gets A then K (dest 0, ranks 1, 13), handshakes spaced 2 cycles -> numbers[9:0] = p1min 11, p1max 21; blackjack = 3'b001; bust = 0.
- p2 gets 10, 9, 5 -> p2min = p2max = 24; bust = 3'b010; a fourth card is still accepted and p2 saturates correctly. Check by driving eight 13s -> p2min = 31, 8th card card_error=1, count stays 7.
- Dealer gets 6 then A with hide_hole=1 -> dmin = dmax = 6. Drop hide_hole -> next cycle dmin=7, dmax=17.
- p1 gets A, A, 9 -> p1min 11, p1max 21; blackjack[0]=0 (3 cards).
- card_dest=3 or card_rank=0 with valid -> accepted, card_error single-cycle pulse, numbers unchanged.
- clear_hands asserted in the same cycle as card_valid -> card_ready=0, card not taken. After CLR, numbers=0, bust=0, blackjack=0, and a held card is then accepted. Separately, assert reset during ADD -> all outputs 0 immediately.
